mar_agu: RTL
============

// Module: mar_agu
// PURPOSE
//  Parametrised memory address register with address-generation unit and data-memory handshake.
//  - Captures an address from the C bus, or steps it by a programmable stride inside a wrap window.
//  - Runs one read/write access at a time: req/ack handshake with timeout and optional post-increment.
//  - Sits between the control unit/C bus and data memory; drives the memory address, enable and write-enable.
// PARAMETERS
//  ADDR_W    24        address width
//  STRIDE_W  8         stride width (zero-extended to ADDR_W)
//  WRAP_LO   24'h000000 lowest legal address (window base)
//  WRAP_HI   24'hFFFFFF highest legal address; WRAP_HI >= WRAP_LO
//  TIMEOUT   15        max ACCESS cycles without mem_ack before abort (>=1, fits in 8 bits)
//  AUTO_INC  0         1: add stride_q to data_addr after each successful access
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  load       in   1         capture C_bus into data_addr
//  inc        in   1         data_addr += stride (wrapping)
//  dec        in   1         data_addr -= stride (wrapping)
//  stride     in   STRIDE_W  step size for inc/dec; latched as stride_q when a request is accepted
//  C_bus      in   ADDR_W    address source for load
//  rd_req     in   1         start read access (level, sampled in IDLE)
//  wr_req     in   1         start write access (level, sampled in IDLE)
//  mem_ack    in   1         memory completion strobe
//  data_addr  out  ADDR_W    registered memory address
//  mem_en     out  1         memory enable, high only in ACCESS
//  mem_we     out  1         write enable, high only in ACCESS of a write
//  busy       out  1         high in ACCESS and DONE
//  done       out  1         one-cycle pulse: access finished (ok or error)
//  err_code   out  2         00 ok, 01 address out of window, 10 timeout
// BEHAVIOUR
//  - Reset (async, rst_n=0): data_addr=0, mem_en=0, mem_we=0, busy=0, done=0, err_code=00, state=IDLE, wait counter=0, stride_q=0.
//    Reset mid-access aborts immediately; there is no done pulse.
//  - Window: W = WRAP_HI-WRAP_LO+1. All arithmetic is in ADDR_W+1 bits. stride must be <= W; a larger stride is undefined.
//  - inc: s = addr+stride; if s > WRAP_HI then addr = s-W, else addr = s.
//  - dec: d = addr-stride, signed; if d < WRAP_LO then addr = d+W, else addr = d.
//  - inc/dec from an address outside the window: result undefined, but no X may be produced.
//  - Address update priority (IDLE only, no request this cycle): load > inc > dec.
//    inc&dec without load = no change. load stores any value, in range or not, and clears err_code.
//  - Outside IDLE, or in the IDLE cycle a request is accepted, load/inc/dec are ignored.
//  - IDLE, rd_req|wr_req sampled high: wr_req wins if both are high. stride_q <= stride.
//    - data_addr outside [WRAP_LO,WRAP_HI]: err_code=01 and go to DONE. mem_en never asserts.
//    - Otherwise: err_code=00, counter=0, go to ACCESS.
//  - ACCESS: mem_en=1, mem_we=(write). Address is held.
//    - mem_ack=1: go to DONE, err_code=00. If AUTO_INC=1, data_addr advances by stride_q with wrap.
//    - Otherwise counter++. When counter reaches TIMEOUT: err_code=10, go to DONE.
//    - mem_ack on the same edge as the timeout: ack wins.
//  - DONE: done=1 for exactly one cycle, mem_en=0, then go to IDLE. Requests are not sampled in DONE.
//  - err_code holds until the next accepted request or load.
//  - mem_ack is ignored in IDLE and DONE.
//  - Latency: request accepted at edge N gives mem_en=1 from N. Ack at edge M gives done=1 from M to M+1.
//    Minimum request-to-request spacing is 3 cycles.
// TESTING
//  1. Reset defaults; load C_bus=0x000123 -> data_addr=0x000123 next cycle, err_code=00.
//  2. WRAP_LO=0x100, WRAP_HI=0x1FF, addr=0x1FC:
//     - inc stride=8 -> 0x104
//     - dec stride=8 from 0x102 -> 0x1FA
//     - inc&dec together -> unchanged
//  3. rd_req with addr 0x150, mem_ack after 3 cycles -> mem_en high 4 cycles, mem_we=0, done one pulse, err_code=00.
//     With AUTO_INC=1 and stride=4 -> addr=0x154.
//  4. wr_req&rd_req together, TIMEOUT=4, no ack -> mem_we=1, mem_en high 4 cycles, done with err_code=10.
//     Address unchanged even with AUTO_INC=1.
//  5. load 0x0050 (outside the window), then rd_req -> mem_en stays 0, done pulse, err_code=01.
//     A following load clears err_code.
//  6. rst_n low mid-ACCESS -> all outputs 0 immediately. load/inc during busy -> ignored.

Source files
------------

// File: rtl/mar_agu.sv
// Memory address register with stride-based address generation inside a wrap window,
// plus a single-outstanding read/write handshake to data memory with timeout.
module mar_agu #(
    parameter int unsigned ADDR_W   = 24,
    parameter int unsigned STRIDE_W = 8,
    parameter logic [ADDR_W-1:0] WRAP_LO = '0,
    parameter logic [ADDR_W-1:0] WRAP_HI = '1,
    parameter int unsigned TIMEOUT  = 15,
    parameter bit          AUTO_INC = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                inc,
    input  logic                dec,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [ADDR_W-1:0]   C_bus,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic                mem_ack,
    output logic [ADDR_W-1:0]   data_addr,
    output logic                mem_en,
    output logic                mem_we,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err_code
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [ADDR_W:0] LO_X = {1'b0, WRAP_LO};
    localparam logic [ADDR_W:0] HI_X = {1'b0, WRAP_HI};
    localparam logic [ADDR_W:0] WIN  = HI_X - LO_X + {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]      TO   = 8'(TIMEOUT);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr_q, addr_nx;
    logic [1:0]          err_q, err_nx;
    logic [7:0]          cnt_q, cnt_nx;
    logic [STRIDE_W-1:0] stride_q, stride_nx;
    logic                wr_q, wr_nx;
    logic [ADDR_W:0]     offset;
    logic                in_window;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a,
                                                   input logic [STRIDE_W-1:0] s);
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + (ADDR_W+1)'(s);
        if (sum > HI_X) sum = sum - WIN;
        return ADDR_W'(sum);
    endfunction

    function automatic logic [ADDR_W-1:0] wrap_dec(input logic [ADDR_W-1:0] a,
                                                   input logic [STRIDE_W-1:0] s);
        logic signed [ADDR_W:0] diff;
        diff = $signed({1'b0, a}) - $signed((ADDR_W+1)'(s));
        if (diff < $signed(LO_X)) diff = diff + $signed(WIN);
        return ADDR_W'(diff);
    endfunction

    // Offset from the window base; an address below WRAP_LO wraps to a huge offset.
    assign offset    = {1'b0, addr_q} - LO_X;
    assign in_window = (offset < WIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        addr_nx   = addr_q;
        err_nx    = err_q;
        cnt_nx    = cnt_q;
        stride_nx = stride_q;
        wr_nx     = wr_q;
        case (state)
            IDLE: begin
                if (rd_req || wr_req) begin
                    stride_nx = stride;
                    wr_nx     = wr_req;
                    if (!in_window) begin
                        err_nx   = 2'b01;
                        state_nx = DONE;
                    end else begin
                        err_nx   = 2'b00;
                        cnt_nx   = '0;
                        state_nx = ACCESS;
                    end
                end else if (load) begin
                    addr_nx = C_bus;
                    err_nx  = 2'b00;
                end else if (inc && !dec) begin
                    addr_nx = wrap_inc(addr_q, stride);
                end else if (dec && !inc) begin
                    addr_nx = wrap_dec(addr_q, stride);
                end
            end
            ACCESS: begin
                cnt_nx = cnt_q + 8'd1;
                if (mem_ack) begin
                    err_nx   = 2'b00;
                    state_nx = DONE;
                    if (AUTO_INC) addr_nx = wrap_inc(addr_q, stride_q);
                end else if (cnt_nx == TO) begin
                    err_nx   = 2'b10;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
            stride_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            addr_q   <= addr_nx;
            err_q    <= err_nx;
            cnt_q    <= cnt_nx;
            stride_q <= stride_nx;
            wr_q     <= wr_nx;
        end
    end

    assign data_addr = addr_q;
    assign err_code  = err_q;
    assign mem_en    = (state == ACCESS);
    assign mem_we    = (state == ACCESS) && wr_q;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule
